// File: rtl/tx_uart_manager.sv
// Response frame builder for the UART transmit path: body bytes for the latched
// response code followed by two full-stop bytes, handed to the serializer one at a time.
module tx_uart_manager #(
  parameter logic [39:0] ID_STR   = 40'h48_69_20_49_44,
  parameter logic [7:0]  FS_BYTE  = 8'hFF,
  parameter logic [7:0]  PAD_BYTE = 8'hFE
) (
  input  logic       Clk,
  input  logic       nRst,
  input  logic       Send,
  input  logic [3:0] RespCode,
  input  logic [7:0] Payload,
  output logic [7:0] TxData,
  output logic       TxStart,
  input  logic       TxBusy,
  output logic       TBusy,
  output logic       Err,
  output logic       Clipped
);

  typedef enum logic [2:0] {IDLE, ARM, STRT, ACK, SEND} state_t;

  state_t     state, state_next;
  logic [3:0] code, code_next;
  logic [7:0] pay, pay_next;
  logic [2:0] len, len_next;
  logic [2:0] index, index_next;
  logic [7:0] tx_data_next;
  logic       tx_start_next, err_next, clipped_next;
  logic [7:0] cur_byte;
  logic       cur_is_pay;
  logic [2:0] accept_body;

  // Body length per response code; zero marks an unsupported code.
  function automatic logic [2:0] body_length(input logic [3:0] c);
    case (c)
      4'b0001:                            body_length = 3'd5;
      4'b0011, 4'b0101, 4'b0111, 4'b1111: body_length = 3'd2;
      4'b1000, 4'b1001, 4'b1010, 4'b1011: body_length = 3'd3;
      default:                            body_length = 3'd0;
    endcase
  endfunction

  assign accept_body = body_length(RespCode);
  assign TBusy       = (state != IDLE);

  always_comb begin
    cur_byte   = FS_BYTE;
    cur_is_pay = 1'b0;
    if (index < len - 3'd2) begin
      case (code)
        4'b0001:
          case (index)
            3'd0:    cur_byte = ID_STR[39:32];
            3'd1:    cur_byte = ID_STR[31:24];
            3'd2:    cur_byte = ID_STR[23:16];
            3'd3:    cur_byte = ID_STR[15:8];
            default: cur_byte = ID_STR[7:0];
          endcase
        4'b0011: cur_byte = 8'h47;
        4'b0101: cur_byte = (index == 3'd0) ? 8'h4C : 8'hC4;
        4'b0111: if (index == 3'd0) cur_byte = 8'h67; else cur_is_pay = 1'b1;
        4'b1000: if (index < 3'd2) cur_byte = 8'hAD; else cur_is_pay = 1'b1;
        4'b1001: if (index < 3'd2) cur_byte = 8'hBD; else cur_is_pay = 1'b1;
        4'b1010: if (index < 3'd2) cur_byte = 8'hDA; else cur_is_pay = 1'b1;
        4'b1011: if (index < 3'd2) cur_byte = 8'hDB; else cur_is_pay = 1'b1;
        4'b1111: cur_byte = (index == 3'd0) ? 8'h72 : 8'h52;
        default: cur_byte = FS_BYTE;
      endcase
    end
    // A payload equal to the delimiter would end the frame early at the receiver.
    if (cur_is_pay) cur_byte = (pay == FS_BYTE) ? PAD_BYTE : pay;
  end

  always_comb begin
    state_next    = state;
    code_next     = code;
    pay_next      = pay;
    len_next      = len;
    index_next    = index;
    tx_data_next  = TxData;
    tx_start_next = 1'b0;
    err_next      = 1'b0;
    clipped_next  = 1'b0;
    case (state)
      IDLE:
        if (Send) begin
          code_next = RespCode;
          pay_next  = Payload;
          if (accept_body != 3'd0) begin
            len_next   = accept_body + 3'd2;
            index_next = 3'd0;
            state_next = ARM;
          end else begin
            err_next = 1'b1;
          end
        end
      ARM:
        if (!TxBusy) state_next = STRT;
      STRT: begin
        tx_data_next  = cur_byte;
        tx_start_next = 1'b1;
        clipped_next  = cur_is_pay && (pay == FS_BYTE);
        state_next    = ACK;
      end
      ACK:
        if (TxBusy) state_next = SEND;
      SEND:
        if (!TxBusy) begin
          index_next = index + 3'd1;
          state_next = (index + 3'd1 == len) ? IDLE : STRT;
        end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state   <= IDLE;
      code    <= '0;
      pay     <= '0;
      len     <= '0;
      index   <= '0;
      TxData  <= '0;
      TxStart <= 1'b0;
      Err     <= 1'b0;
      Clipped <= 1'b0;
    end else begin
      state   <= state_next;
      code    <= code_next;
      pay     <= pay_next;
      len     <= len_next;
      index   <= index_next;
      TxData  <= tx_data_next;
      TxStart <= tx_start_next;
      Err     <= err_next;
      Clipped <= clipped_next;
    end
  end

endmodule

// File: doc/tx_uart_manager.md
Name: tx_uart_manager

Overview:
Transmit-side companion to the command receiver. On request it builds a response frame from a 4-bit response code and an optional payload byte, appends the 0xFF 0xFF full-stop delimiter, and feeds the frame byte-by-byte to the byte-level UART transmitter. It sits between the command/test control logic and the TxUart serializer.

Parameters:
ID_STR, 40'h48_69_20_49_44, 5-byte ID reply, MSB byte sent first ("Hi ID").
FS_BYTE, 8'hFF, delimiter byte; each frame ends with two of these.
PAD_BYTE, 8'hFE, substitute sent in place of a payload byte equal to FS_BYTE.

Ports:
Clk  in  1  system clock, rising edge
nRst  in  1  asynchronous active-low reset
Send  in  1  request; sampled only while TBusy=0
RespCode  in  4  response selector, latched on accept
Payload  in  8  data byte, latched on accept
TxData  out  8  byte to serializer; stable from TxStart until TxBusy falls
TxStart  out  1  one-cycle pulse: serializer loads TxData
TxBusy  in  1  serializer busy (high while shifting)
TBusy  out  1  high from the cycle after accept until frame complete
Err  out  1  one-cycle pulse: unsupported RespCode
Clipped  out  1  one-cycle pulse when a payload byte was replaced by PAD_BYTE

Behaviour:
- Reset (async, nRst=0): state IDLE, TxData=0, TxStart=0, TBusy=0, Err=0, Clipped=0, index=0. A reset mid-frame aborts immediately and sends no further bytes. The partial serializer byte is the serializer's concern.
- Frame table (body bytes, then FS_BYTE, FS_BYTE):
  0001: ID_STR (5)
  0011: 47 47
  0101: 4C C4
  0111: 67 P
  1000: AD AD P
  1001: BD BD P
  1010: DA DA P
  1011: DB DB P
  1111: 72 52
  P is the latched Payload. If P==FS_BYTE, PAD_BYTE is sent instead and Clipped pulses on that byte's TxStart cycle.
- Any other code: no bytes sent, Err=1 for one cycle after accept, TBusy stays 0, state stays IDLE.
- Accept: rising Clk with Send=1 and TBusy=0 latches RespCode and Payload, sets len = body+2 and index=0. Send is level-sampled. Holding Send high re-triggers on the first cycle after the frame ends.
- State machine:
  IDLE -> ARM on a valid accept.
  ARM: wait for TxBusy=0, then go to STRT.
  STRT: drive TxData=byte[index] and TxStart=1 for one cycle, then go to ACK.
  ACK: wait for TxBusy=1, then go to SEND.
  SEND: wait for TxBusy=0. Then index+1. If index+1==len go to IDLE with TBusy=0, else go to STRT.
- Latency: if TxBusy=0, the first TxStart occurs 2 cycles after the accept edge. Consecutive bytes have at least 1 cycle of TxBusy low between them.
- TxBusy already high at accept: hold in ARM, no TxStart issued.
- TxData holds its last value in IDLE. Index width is 3 bits, maximum len is 7, and index never wraps.
- Send while TBusy=1 is ignored, not queued.

Test Plan:
- RespCode=0011, Send pulse, serializer model with 10-cycle busy -> TxData sequence 47,47,FF,FF; exactly 4 TxStart pulses; TBusy falls after the 4th TxBusy fall.
- RespCode=1001, Payload=5A -> BD,BD,5A,FF,FF; Payload change after accept has no effect.
- RespCode=0111, Payload=FF -> 67,FE,FF,FF; one Clipped pulse coincident with the 2nd TxStart.
- RespCode=0001 -> 48,69,20,49,44,FF,FF. RespCode=0100 -> Err single pulse, no TxStart, TBusy=0.
- TxBusy held high at accept for 20 cycles -> no TxStart until TxBusy low; then first TxStart 1 cycle later.
- nRst low after the 2nd byte of 1111 -> outputs zeroed asynchronously, no further TxStart. A new Send after release sends the complete 72,52,FF,FF.
